// File: rtl/bilinear_neighbor_fetch.sv
// Fetches the 2x2 source neighbourhood of one output pixel for bilinear_calculation.
// Optional EDGE_CLAMP_EN clamps x+1 / y+1 to the last source column / row.
module bilinear_neighbor_fetch #(
    parameter int DATA_W  = 16,
    parameter int COORD_W = 16,
    parameter int COEF_W  = 17
) (
    input  logic               vin_clk,
    input  logic               rst,
    input  logic               frame_sync_n,
    input  logic [COORD_W-1:0] vin_xres,
    input  logic [COORD_W-1:0] vin_yres,
    input  logic               coo_valid,
    output logic               coo_ready,
    input  logic [COORD_W-1:0] coordinate_x,
    input  logic [COORD_W-1:0] coordinate_y,
    input  logic [COEF_W-1:0]  coefficient1,
    input  logic [COEF_W-1:0]  coefficient2,
    input  logic [COEF_W-1:0]  coefficient3,
    input  logic [COEF_W-1:0]  coefficient4,
    output logic               mem_rd_req,
    input  logic               mem_rd_gnt,
    output logic [31:0]        mem_rd_addr,
    input  logic               mem_rd_valid,
    input  logic [DATA_W-1:0]  mem_rd_data,
    output logic               fetch_valid,
    input  logic               fetch_ready,
    output logic [DATA_W-1:0]  doutbx,
    output logic [DATA_W-1:0]  doutbx1,
    output logic [DATA_W-1:0]  doutby,
    output logic [DATA_W-1:0]  doutby1,
    output logic [COEF_W-1:0]  cal_coefficient1,
    output logic [COEF_W-1:0]  cal_coefficient2,
    output logic [COEF_W-1:0]  cal_coefficient3,
    output logic [COEF_W-1:0]  cal_coefficient4
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_OUT} state_t;

    localparam logic [COORD_W-1:0] C_ONE = COORD_W'(1);

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_idx;
    logic [2:0]          r_nbeat;
    logic [2:0]          r_cnt;
    logic [COORD_W-1:0]  r_x;
    logic [COORD_W-1:0]  r_y;
    logic [COORD_W-1:0]  w_x1;
    logic [COORD_W-1:0]  w_y1;
    logic [COORD_W-1:0]  w_col;
    logic [COORD_W-1:0]  w_row;
    logic [15:0]         w_col16;
    logic [15:0]         w_row16;
    logic                w_acc;
    logic                w_gnt;
    logic                w_ret;
    logic                w_beat;
    logic [2:0]          w_nbeat_nx;

`ifdef EDGE_CLAMP_EN
    assign w_x1 = (r_x >= vin_xres - C_ONE) ? vin_xres - C_ONE : r_x + C_ONE;
    assign w_y1 = (r_y >= vin_yres - C_ONE) ? vin_yres - C_ONE : r_y + C_ONE;
`else
    logic w_unused_res;
    assign w_unused_res = ^{vin_xres, vin_yres};
    assign w_x1 = r_x + C_ONE;
    assign w_y1 = r_y + C_ONE;
`endif

    // idx bit 0 selects the right column, bit 1 the lower row
    assign w_col   = r_idx[0] ? w_x1 : r_x;
    assign w_row   = r_idx[1] ? w_y1 : r_y;
    assign w_col16 = 16'(w_col);
    assign w_row16 = 16'(w_row);
    assign mem_rd_addr = mem_rd_req ? {w_row16, w_col16[13:0], 2'b00} : 32'd0;

    assign w_acc  = coo_valid && coo_ready;
    assign w_gnt  = mem_rd_req && mem_rd_gnt;
    assign w_ret  = mem_rd_valid && (r_cnt != 3'd0);
    // beats arriving after an abort only count down the outstanding counter
    assign w_beat = w_ret && frame_sync_n &&
                    ((r_state == S_REQ) || (r_state == S_WAIT));
    assign w_nbeat_nx = r_nbeat + {2'b00, w_beat};

    always_ff @(posedge vin_clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        coo_ready   = 1'b0;
        mem_rd_req  = 1'b0;
        fetch_valid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                coo_ready = !rst && frame_sync_n && (r_cnt == 3'd0);
                if (coo_valid && coo_ready) w_next = S_REQ;
            end
            S_REQ: begin
                mem_rd_req = 1'b1;
                if (mem_rd_gnt && (r_idx == 2'd3))
                    w_next = (w_nbeat_nx == 3'd4) ? S_OUT : S_WAIT;
            end
            S_WAIT: begin
                if (w_nbeat_nx == 3'd4) w_next = S_OUT;
            end
            S_OUT: begin
                fetch_valid = 1'b1;
                if (fetch_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (!frame_sync_n) w_next = S_IDLE;
    end

    always_ff @(posedge vin_clk) begin
        if (rst) begin
            r_idx            <= '0;
            r_nbeat          <= '0;
            r_cnt            <= '0;
            r_x              <= '0;
            r_y              <= '0;
            doutbx           <= '0;
            doutbx1          <= '0;
            doutby           <= '0;
            doutby1          <= '0;
            cal_coefficient1 <= '0;
            cal_coefficient2 <= '0;
            cal_coefficient3 <= '0;
            cal_coefficient4 <= '0;
        end else begin
            unique case (1'b1)
                (w_gnt && !w_ret): r_cnt <= r_cnt + 3'd1;
                (!w_gnt && w_ret): r_cnt <= r_cnt - 3'd1;
                default: ;
            endcase
            if (w_acc) begin
                r_idx            <= '0;
                r_nbeat          <= '0;
                r_x              <= coordinate_x;
                r_y              <= coordinate_y;
                cal_coefficient1 <= coefficient1;
                cal_coefficient2 <= coefficient2;
                cal_coefficient3 <= coefficient3;
                cal_coefficient4 <= coefficient4;
            end
            if (w_gnt) r_idx <= r_idx + 2'd1;
            if (w_beat) begin
                r_nbeat <= w_nbeat_nx;
                unique case (r_nbeat[1:0])
                    2'd0: doutbx  <= mem_rd_data;
                    2'd1: doutbx1 <= mem_rd_data;
                    2'd2: doutby  <= mem_rd_data;
                    default: doutby1 <= mem_rd_data;
                endcase
            end
        end
    end

endmodule
